// File: rtl/cpu_pkg.sv
// Shared constants for the instruction sequencer: FSM state codes, opcode
// classes, trap causes and the PC-update selector.
package cpu_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_WAIT_I = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_TRAP   = 3'd6;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSN_MRET   = 32'h3020_0073;

  localparam logic [1:0] CAUSE_ILLEGAL       = 2'd0;
  localparam logic [1:0] CAUSE_ECALL         = 2'd1;
  localparam logic [1:0] CAUSE_FETCH_TIMEOUT = 2'd2;

  // Status code the decoder reports for an illegal encoding
  localparam logic [1:0] INVALID_INSTRUCTION = 2'd2;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_ECALL, CLS_MRET
  } insn_class_e;

  typedef enum logic [2:0] {
    PC_HOLD, PC_SEQ, PC_TGT, PC_MEPC, PC_TRAP
  } pc_sel_e;

  function automatic insn_class_e classify(input logic [31:0] insn);
    insn_class_e cls;
    cls = CLS_ALU;
    case (insn[6:2])
      OPC_LOAD:           cls = CLS_LOAD;
      OPC_STORE:          cls = CLS_STORE;
      OPC_BRANCH:         cls = CLS_BRANCH;
      OPC_JAL, OPC_JALR:  cls = CLS_JUMP;
      OPC_SYSTEM: begin
        if (insn == INSN_ECALL || insn == INSN_EBREAK) cls = CLS_ECALL;
        else if (insn == INSN_MRET)                    cls = CLS_MRET;
      end
      default:            cls = CLS_ALU;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/seq_pc_unit.sv
// Program counter and trap-return register; applies the PC update chosen
// by the sequencer FSM.
module seq_pc_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  pc_sel_e     pc_sel,
  input  logic [31:0] tgt_pc,
  output logic [31:0] pc,
  output logic [31:0] mepc
);

  logic [31:0] pc_reg, pc_next;
  logic [31:0] mepc_reg, mepc_next;

  always_comb begin
    pc_next   = pc_reg;
    mepc_next = mepc_reg;
    case (pc_sel)
      PC_SEQ:  pc_next = pc_reg + 32'd4;
      PC_TGT:  pc_next = tgt_pc;
      PC_MEPC: pc_next = mepc_reg;
      PC_TRAP: begin
        pc_next   = TRAP_PC;
        mepc_next = pc_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg   <= RESET_PC;
      mepc_reg <= 32'd0;
    end else begin
      pc_reg   <= pc_next;
      mepc_reg <= mepc_next;
    end
  end

  assign pc   = pc_reg;
  assign mepc = mepc_reg;

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory and
// write-back control with trap handling and a fetch timeout.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC       = 32'h0000_0100,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic        dec_en,
  input  logic        dec_invalid,
  input  logic        br_taken,
  input  logic [31:0] tgt_pc,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        reg_we,
  output logic [31:0] pc,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] mepc
);

  localparam logic [15:0] TMO_LAST = 16'(FETCH_TIMEOUT - 1);

  logic [2:0]  state_reg, state_next;
  logic [31:0] ir_reg, ir_next;
  logic [15:0] tmo_reg, tmo_next;
  logic        taken_reg, taken_next;
  logic [1:0]  cause_reg, cause_next;
  logic [1:0]  dec_status;
  pc_sel_e     pc_sel;
  insn_class_e cls;

  assign cls        = classify(ir_reg);
  assign dec_status = dec_invalid ? INVALID_INSTRUCTION : 2'd0;

  always_comb begin
    state_next = state_reg;
    ir_next    = ir_reg;
    tmo_next   = tmo_reg;
    taken_next = taken_reg;
    cause_next = cause_reg;
    pc_sel     = PC_HOLD;
    case (state_reg)
      ST_FETCH: begin
        tmo_next   = 16'd0;
        state_next = ST_WAIT_I;
      end
      ST_WAIT_I: begin
        // An ack arriving on the last allowed cycle still completes the fetch
        if (imem_ack) begin
          ir_next    = imem_rdata;
          state_next = ST_DECODE;
        end else if (tmo_reg == TMO_LAST) begin
          cause_next = CAUSE_FETCH_TIMEOUT;
          state_next = ST_TRAP;
        end else begin
          tmo_next = tmo_reg + 16'd1;
        end
      end
      ST_DECODE: begin
        if (dec_status == INVALID_INSTRUCTION || ir_reg[1:0] != 2'b11) begin
          cause_next = CAUSE_ILLEGAL;
          state_next = ST_TRAP;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        taken_next = br_taken;
        case (cls)
          CLS_LOAD, CLS_STORE: state_next = ST_MEM;
          CLS_ECALL: begin
            cause_next = CAUSE_ECALL;
            state_next = ST_TRAP;
          end
          CLS_MRET: begin
            pc_sel     = PC_MEPC;
            state_next = ST_FETCH;
          end
          default: state_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (dmem_ack) begin
          if (cls == CLS_STORE) begin
            pc_sel     = PC_SEQ;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end
      end
      ST_WB: begin
        state_next = ST_FETCH;
        if (cls == CLS_JUMP)        pc_sel = PC_TGT;
        else if (cls == CLS_BRANCH) pc_sel = taken_reg ? PC_TGT : PC_SEQ;
        else                        pc_sel = PC_SEQ;
      end
      ST_TRAP: begin
        pc_sel     = PC_TRAP;
        state_next = ST_FETCH;
      end
      default: state_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_FETCH;
      ir_reg    <= 32'd0;
      tmo_reg   <= 16'd0;
      taken_reg <= 1'b0;
      cause_reg <= 2'd0;
    end else begin
      state_reg <= state_next;
      ir_reg    <= ir_next;
      tmo_reg   <= tmo_next;
      taken_reg <= taken_next;
      cause_reg <= cause_next;
    end
  end

  seq_pc_unit #(
    .RESET_PC (RESET_PC),
    .TRAP_PC  (TRAP_PC)
  ) u_pc (
    .clk    (clk),
    .rst_n  (rst_n),
    .pc_sel (pc_sel),
    .tgt_pc (tgt_pc),
    .pc     (pc),
    .mepc   (mepc)
  );

  // Strobes are forced low while reset is held, even though the state is FETCH
  assign imem_req   = rst_n && (state_reg == ST_FETCH || state_reg == ST_WAIT_I);
  assign dec_en     = rst_n && (state_reg == ST_DECODE);
  assign dmem_req   = rst_n && (state_reg == ST_MEM);
  assign dmem_we    = rst_n && (state_reg == ST_MEM) && (cls == CLS_STORE);
  assign reg_we     = rst_n && (state_reg == ST_WB) && (cls != CLS_BRANCH);
  assign trap       = rst_n && (state_reg == ST_TRAP);
  assign trap_cause = cause_reg;
  assign imem_addr  = pc;
  assign ir         = ir_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus random
// instruction streams checked against a per-instruction latency/PC model.
module tb_instr_sequencer;

  localparam logic [31:0] RESET_PC      = 32'h0000_0000;
  localparam logic [31:0] TRAP_PC       = 32'h0000_0100;
  localparam int          FETCH_TIMEOUT = 16;

  localparam logic [31:0] I_ADDI   = 32'h0050_0093;
  localparam logic [31:0] I_ADD    = 32'h0020_81b3;
  localparam logic [31:0] I_LUI    = 32'h1234_50b7;
  localparam logic [31:0] I_LW     = 32'h0000_a103;
  localparam logic [31:0] I_SW     = 32'h0011_2023;
  localparam logic [31:0] I_BEQ    = 32'h0000_0463;
  localparam logic [31:0] I_JAL    = 32'h0080_00ef;
  localparam logic [31:0] I_JALR   = 32'h0000_80e7;
  localparam logic [31:0] I_ECALL  = 32'h0000_0073;
  localparam logic [31:0] I_EBREAK = 32'h0010_0073;
  localparam logic [31:0] I_MRET   = 32'h3020_0073;
  localparam logic [31:0] I_ILL    = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req, dec_en, dmem_req, dmem_we, reg_we, trap;
  logic [31:0] imem_addr, ir, pc, mepc;
  logic [1:0]  trap_cause;
  logic        imem_ack = 1'b0, dec_invalid = 1'b0, br_taken = 1'b0, dmem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0, tgt_pc = 32'd0;

  instr_sequencer #(
    .RESET_PC      (RESET_PC),
    .TRAP_PC       (TRAP_PC),
    .FETCH_TIMEOUT (FETCH_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .ir          (ir),
    .dec_en      (dec_en),
    .dec_invalid (dec_invalid),
    .br_taken    (br_taken),
    .tgt_pc      (tgt_pc),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_ack    (dmem_ack),
    .reg_we      (reg_we),
    .pc          (pc),
    .trap        (trap),
    .trap_cause  (trap_cause),
    .mepc        (mepc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Architectural model state
  logic [31:0] m_pc = RESET_PC, m_mepc = 32'd0, m_ir = 32'd0;
  int exp_cycles, exp_dec, exp_we, exp_we_cyc, exp_dreq, exp_dwe, exp_trap;
  logic [1:0] exp_cause;

  int obs_cycles, obs_dec, obs_we, obs_we_cyc, obs_dreq, obs_dwe, obs_trap, obs_addr_bad;
  logic [1:0]  obs_cause;
  logic [31:0] obs_pc, obs_mepc, obs_ir;
  bit obs_hang;

  // Model: per-instruction cycle count, strobe counts and PC/mepc effect,
  // expressed as a latency table (FETCH + WAIT_I*(iw+1) + DECODE + ...).
  task automatic predict(input logic [31:0] insn, input int iw, input int dw,
                         input logic br, input logic [31:0] tgt, input logic dinv);
    logic [4:0] opc;
    opc = insn[6:2];
    exp_dec = 0; exp_we = 0; exp_we_cyc = -1; exp_dreq = 0; exp_dwe = 0;
    exp_trap = 0; exp_cause = 2'd0;
    if (iw >= FETCH_TIMEOUT) begin
      exp_cycles = FETCH_TIMEOUT + 2;
      exp_trap = 1; exp_cause = 2'd2; m_mepc = m_pc; m_pc = TRAP_PC;
    end else begin
      m_ir = insn; exp_dec = 1;
      if (dinv || insn[1:0] != 2'b11) begin
        exp_cycles = iw + 4;
        exp_trap = 1; exp_cause = 2'd0; m_mepc = m_pc; m_pc = TRAP_PC;
      end else if (opc == 5'b00000) begin
        exp_cycles = iw + 5 + dw; exp_dreq = dw;
        exp_we = 1; exp_we_cyc = iw + 4 + dw; m_pc = m_pc + 32'd4;
      end else if (opc == 5'b01000) begin
        exp_cycles = iw + 4 + dw; exp_dreq = dw; exp_dwe = dw; m_pc = m_pc + 32'd4;
      end else if (opc == 5'b11000) begin
        exp_cycles = iw + 5; m_pc = br ? tgt : m_pc + 32'd4;
      end else if (opc == 5'b11011 || opc == 5'b11001) begin
        exp_cycles = iw + 5; exp_we = 1; exp_we_cyc = iw + 4; m_pc = tgt;
      end else if (insn == I_ECALL || insn == I_EBREAK) begin
        exp_cycles = iw + 5;
        exp_trap = 1; exp_cause = 2'd1; m_mepc = m_pc; m_pc = TRAP_PC;
      end else if (insn == I_MRET) begin
        exp_cycles = iw + 4; m_pc = m_mepc;
      end else begin
        exp_cycles = iw + 5; exp_we = 1; exp_we_cyc = iw + 4; m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Acts as instruction and data memory for one instruction, starting at a
  // negedge in the fetch phase and ending at the negedge of the next fetch.
  task automatic run_instr(input logic [31:0] insn, input int iw, input int dw,
                           input logic br, input logic [31:0] tgt, input logic dinv);
    int n_i, n_d;
    bit seen_low;
    n_i = 0; n_d = 0; seen_low = 0;
    obs_cycles = 0; obs_dec = 0; obs_we = 0; obs_we_cyc = -1; obs_dreq = 0; obs_dwe = 0;
    obs_trap = 0; obs_cause = 2'd0; obs_addr_bad = 0; obs_hang = 0;
    imem_rdata = insn; br_taken = br; tgt_pc = tgt; dec_invalid = dinv;
    while (!(seen_low && imem_req)) begin
      if (obs_cycles >= 200) begin
        obs_hang = 1;
        break;
      end
      if (imem_addr !== pc) obs_addr_bad++;
      if (imem_req) n_i++; else seen_low = 1;
      if (dec_en) obs_dec++;
      if (reg_we) begin obs_we++; obs_we_cyc = obs_cycles; end
      if (dmem_req) n_d++;
      if (dmem_req) obs_dreq++;
      if (dmem_we) obs_dwe++;
      if (trap) begin obs_trap++; obs_cause = trap_cause; end
      imem_ack = imem_req && (n_i == iw + 2);
      dmem_ack = dmem_req && (n_d == dw);
      obs_cycles++;
      @(negedge clk);
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    obs_pc = pc; obs_mepc = mepc; obs_ir = ir;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (pc !== RESET_PC) begin n_bad++; $display("FAIL reset_pc: got %h want %h", pc, RESET_PC); end
    n_cmp++; if (ir !== 32'd0) begin n_bad++; $display("FAIL reset_ir: got %h want 0", ir); end
    n_cmp++; if (mepc !== 32'd0) begin n_bad++; $display("FAIL reset_mepc: got %h want 0", mepc); end
    n_cmp++; if (trap_cause !== 2'd0) begin n_bad++; $display("FAIL reset_cause: got %0d want 0", trap_cause); end
    n_cmp++; if ({imem_req, dec_en, dmem_req, dmem_we, reg_we, trap} !== 6'b0) begin
      n_bad++; $display("FAIL reset_strobes: got %b want 000000", {imem_req, dec_en, dmem_req, dmem_we, reg_we, trap});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      n_bad++; $display("FAIL reset_first_fetch: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, RESET_PC);
    end
    $display("reset: pc=%h ir=%h mepc=%h", pc, ir, mepc);
  endtask

  task automatic test_alu;
    predict(I_ADDI, 0, 1, 1'b0, 32'd0, 1'b0);
    run_instr(I_ADDI, 0, 1, 1'b0, 32'd0, 1'b0);
    $display("alu: ir=%h pc=%h we_cyc=%0d cycles=%0d", obs_ir, obs_pc, obs_we_cyc, obs_cycles);
    n_cmp++; if (obs_ir !== I_ADDI) begin n_bad++; $display("FAIL alu_ir: got %h want %h", obs_ir, I_ADDI); end
    n_cmp++; if (obs_dec != 1) begin n_bad++; $display("FAIL alu_dec_en: got %0d cycles want 1", obs_dec); end
    n_cmp++; if (obs_we != 1 || obs_we_cyc != 4) begin
      n_bad++; $display("FAIL alu_reg_we: got %0d at cycle %0d want 1 at cycle 4", obs_we, obs_we_cyc);
    end
    n_cmp++; if (obs_pc !== 32'h4) begin n_bad++; $display("FAIL alu_pc: got %h want 00000004", obs_pc); end
  endtask

  task automatic test_branch;
    predict(I_BEQ, 0, 1, 1'b1, 32'h8, 1'b0);
    run_instr(I_BEQ, 0, 1, 1'b1, 32'h8, 1'b0);
    $display("branch taken: pc=%h reg_we=%0d", obs_pc, obs_we);
    n_cmp++; if (obs_we != 0) begin n_bad++; $display("FAIL br_taken_reg_we: got %0d want 0", obs_we); end
    n_cmp++; if (obs_pc !== 32'h8) begin n_bad++; $display("FAIL br_taken_pc: got %h want 00000008", obs_pc); end
    predict(I_BEQ, 1, 1, 1'b0, 32'h8, 1'b0);
    run_instr(I_BEQ, 1, 1, 1'b0, 32'h8, 1'b0);
    $display("branch not taken: pc=%h", obs_pc);
    n_cmp++; if (obs_pc !== 32'hC) begin n_bad++; $display("FAIL br_not_taken_pc: got %h want 0000000c", obs_pc); end
  endtask

  task automatic test_store;
    predict(I_SW, 0, 3, 1'b0, 32'd0, 1'b0);
    run_instr(I_SW, 0, 3, 1'b0, 32'd0, 1'b0);
    $display("store: dmem_req=%0d dmem_we=%0d reg_we=%0d pc=%h", obs_dreq, obs_dwe, obs_we, obs_pc);
    n_cmp++; if (obs_dreq != 3 || obs_dwe != 3) begin
      n_bad++; $display("FAIL store_dmem: got req=%0d we=%0d want 3/3", obs_dreq, obs_dwe);
    end
    n_cmp++; if (obs_we != 0) begin n_bad++; $display("FAIL store_reg_we: got %0d want 0", obs_we); end
    n_cmp++; if (obs_pc !== 32'h10) begin n_bad++; $display("FAIL store_pc: got %h want 00000010", obs_pc); end
    n_cmp++; if (obs_cycles != 7) begin n_bad++; $display("FAIL store_cycles: got %0d want 7", obs_cycles); end
  endtask

  task automatic test_illegal_mret;
    predict(I_JAL, 0, 1, 1'b0, 32'h40, 1'b0);
    run_instr(I_JAL, 0, 1, 1'b0, 32'h40, 1'b0);
    n_cmp++; if (obs_pc !== 32'h40) begin n_bad++; $display("FAIL jal_pc: got %h want 00000040", obs_pc); end
    predict(I_ILL, 0, 1, 1'b0, 32'd0, 1'b0);
    run_instr(I_ILL, 0, 1, 1'b0, 32'd0, 1'b0);
    $display("illegal: trap=%0d cause=%0d mepc=%h pc=%h", obs_trap, obs_cause, obs_mepc, obs_pc);
    n_cmp++; if (obs_trap != 1 || obs_cause !== 2'd0) begin
      n_bad++; $display("FAIL ill_trap: got trap=%0d cause=%0d want 1/0", obs_trap, obs_cause);
    end
    n_cmp++; if (obs_mepc !== 32'h40) begin n_bad++; $display("FAIL ill_mepc: got %h want 00000040", obs_mepc); end
    n_cmp++; if (obs_pc !== TRAP_PC) begin n_bad++; $display("FAIL ill_pc: got %h want %h", obs_pc, TRAP_PC); end
    predict(I_MRET, 0, 1, 1'b0, 32'd0, 1'b0);
    run_instr(I_MRET, 0, 1, 1'b0, 32'd0, 1'b0);
    $display("mret: pc=%h", obs_pc);
    n_cmp++; if (obs_pc !== 32'h40 || obs_we != 0) begin
      n_bad++; $display("FAIL mret_pc: got pc=%h we=%0d want 00000040/0", obs_pc, obs_we);
    end
  endtask

  task automatic test_fetch_timeout;
    predict(I_ADDI, FETCH_TIMEOUT - 1, 1, 1'b0, 32'd0, 1'b0);
    run_instr(I_ADDI, FETCH_TIMEOUT - 1, 1, 1'b0, 32'd0, 1'b0);
    $display("late ack: trap=%0d pc=%h cycles=%0d", obs_trap, obs_pc, obs_cycles);
    n_cmp++; if (obs_trap != 0 || obs_pc !== 32'h44) begin
      n_bad++; $display("FAIL ack_wins: got trap=%0d pc=%h want 0/00000044", obs_trap, obs_pc);
    end
    predict(I_ADDI, 100000, 1, 1'b0, 32'd0, 1'b0);
    run_instr(I_ADDI, 100000, 1, 1'b0, 32'd0, 1'b0);
    $display("timeout: trap=%0d cause=%0d pc=%h cycles=%0d", obs_trap, obs_cause, obs_pc, obs_cycles);
    n_cmp++; if (obs_trap != 1 || obs_cause !== 2'd2) begin
      n_bad++; $display("FAIL tmo_trap: got trap=%0d cause=%0d want 1/2", obs_trap, obs_cause);
    end
    n_cmp++; if (obs_cycles != FETCH_TIMEOUT + 2) begin
      n_bad++; $display("FAIL tmo_cycles: got %0d want %0d", obs_cycles, FETCH_TIMEOUT + 2);
    end
    n_cmp++; if (obs_pc !== TRAP_PC || obs_mepc !== 32'h44 || obs_dec != 0) begin
      n_bad++; $display("FAIL tmo_pc: got pc=%h mepc=%h dec=%0d want %h/00000044/0", obs_pc, obs_mepc, obs_dec, TRAP_PC);
    end
  endtask

  task automatic test_pc_wrap;
    predict(I_JALR, 0, 1, 1'b0, 32'hFFFF_FFFC, 1'b0);
    run_instr(I_JALR, 0, 1, 1'b0, 32'hFFFF_FFFC, 1'b0);
    predict(I_ADD, 2, 1, 1'b0, 32'd0, 1'b0);
    run_instr(I_ADD, 2, 1, 1'b0, 32'd0, 1'b0);
    $display("wrap: pc=%h", obs_pc);
    n_cmp++; if (obs_pc !== 32'h0) begin n_bad++; $display("FAIL wrap_pc: got %h want 00000000", obs_pc); end
    predict(I_ECALL, 0, 1, 1'b0, 32'd0, 1'b0);
    run_instr(I_ECALL, 0, 1, 1'b0, 32'd0, 1'b0);
    $display("ecall: trap=%0d cause=%0d pc=%h", obs_trap, obs_cause, obs_pc);
    n_cmp++; if (obs_trap != 1 || obs_cause !== 2'd1 || obs_pc !== TRAP_PC) begin
      n_bad++; $display("FAIL ecall: got trap=%0d cause=%0d pc=%h want 1/1/%h", obs_trap, obs_cause, obs_pc, TRAP_PC);
    end
  endtask

  task automatic test_random;
    logic [31:0] pool [0:11];
    logic [31:0] insn, tgt;
    int iw, dw, pick;
    logic br, dinv;
    pool[0] = I_ADDI; pool[1] = I_ADD; pool[2] = I_LUI; pool[3] = I_LW;
    pool[4] = I_SW; pool[5] = I_BEQ; pool[6] = I_JAL; pool[7] = I_JALR;
    pool[8] = I_ECALL; pool[9] = I_EBREAK; pool[10] = I_MRET; pool[11] = I_ILL;
    for (int i = 0; i < 60; i++) begin
      pick = $urandom_range(0, 12);
      insn = (pick == 12) ? $urandom() : pool[pick];
      pick = $urandom_range(0, 9);
      iw   = (pick == 0) ? FETCH_TIMEOUT : (pick == 1) ? FETCH_TIMEOUT - 1 : $urandom_range(0, 3);
      dw   = $urandom_range(1, 4);
      br   = 1'($urandom_range(0, 1));
      tgt  = $urandom();
      tgt[1:0] = 2'b00;
      dinv = ($urandom_range(0, 7) == 0);
      predict(insn, iw, dw, br, tgt, dinv);
      run_instr(insn, iw, dw, br, tgt, dinv);
      $display("rnd%0d: insn=%h iw=%0d dw=%0d br=%0d dinv=%0d -> pc=%h cyc=%0d trap=%0d",
               i, insn, iw, dw, br, dinv, obs_pc, obs_cycles, obs_trap);
      n_cmp++; if (obs_hang) begin n_bad++; $display("FAIL rnd%0d_hang: no new fetch within 200 cycles", i); end
      n_cmp++; if (obs_cycles != exp_cycles) begin n_bad++; $display("FAIL rnd%0d_cycles: got %0d want %0d", i, obs_cycles, exp_cycles); end
      n_cmp++; if (obs_pc !== m_pc) begin n_bad++; $display("FAIL rnd%0d_pc: got %h want %h", i, obs_pc, m_pc); end
      n_cmp++; if (obs_mepc !== m_mepc) begin n_bad++; $display("FAIL rnd%0d_mepc: got %h want %h", i, obs_mepc, m_mepc); end
      n_cmp++; if (obs_ir !== m_ir) begin n_bad++; $display("FAIL rnd%0d_ir: got %h want %h", i, obs_ir, m_ir); end
      n_cmp++; if (obs_dec != exp_dec) begin n_bad++; $display("FAIL rnd%0d_dec_en: got %0d want %0d", i, obs_dec, exp_dec); end
      n_cmp++; if (obs_we != exp_we || obs_we_cyc != exp_we_cyc) begin
        n_bad++; $display("FAIL rnd%0d_reg_we: got %0d@%0d want %0d@%0d", i, obs_we, obs_we_cyc, exp_we, exp_we_cyc);
      end
      n_cmp++; if (obs_dreq != exp_dreq || obs_dwe != exp_dwe) begin
        n_bad++; $display("FAIL rnd%0d_dmem: got req=%0d we=%0d want %0d/%0d", i, obs_dreq, obs_dwe, exp_dreq, exp_dwe);
      end
      n_cmp++; if (obs_trap != exp_trap) begin n_bad++; $display("FAIL rnd%0d_trap: got %0d want %0d", i, obs_trap, exp_trap); end
      if (exp_trap == 1) begin
        n_cmp++; if (obs_cause !== exp_cause) begin n_bad++; $display("FAIL rnd%0d_cause: got %0d want %0d", i, obs_cause, exp_cause); end
      end
      n_cmp++; if (obs_addr_bad != 0) begin n_bad++; $display("FAIL rnd%0d_imem_addr: %0d cycles with imem_addr != pc", i, obs_addr_bad); end
    end
  endtask

  task automatic test_reset_mid_mem;
    int n, k;
    n = 0; k = 0;
    imem_rdata = I_SW; dec_invalid = 1'b0; dmem_ack = 1'b0; imem_ack = 1'b1;
    while (n < 2 && k < 30) begin
      @(negedge clk);
      if (dmem_req) begin n++; imem_ack = 1'b0; end
      k++;
    end
    n_cmp++; if (n != 2) begin n_bad++; $display("FAIL mid_mem_reach: got %0d dmem_req cycles want 2", n); end
    #2 rst_n = 1'b0;
    #1;
    $display("reset mid-mem: dmem_req=%b pc=%h ir=%h", dmem_req, pc, ir);
    n_cmp++; if ({imem_req, dec_en, dmem_req, dmem_we, reg_we, trap} !== 6'b0) begin
      n_bad++; $display("FAIL mid_mem_strobes: got %b want 000000", {imem_req, dec_en, dmem_req, dmem_we, reg_we, trap});
    end
    n_cmp++; if (pc !== RESET_PC || ir !== 32'd0 || mepc !== 32'd0 || trap_cause !== 2'd0) begin
      n_bad++; $display("FAIL mid_mem_regs: got pc=%h ir=%h mepc=%h cause=%0d want %h/0/0/0", pc, ir, mepc, trap_cause, RESET_PC);
    end
    dmem_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC || dmem_req !== 1'b0) begin
      n_bad++; $display("FAIL mid_mem_refetch: got req=%b addr=%h dreq=%b want 1/%h/0", imem_req, imem_addr, dmem_req, RESET_PC);
    end
    @(negedge clk);
    // Now in the wait-for-instruction phase; the stale dmem_ack was ignored
    run_instr(I_ADDI, 0, 1, 1'b0, 32'd0, 1'b0);
    $display("after reset: pc=%h ir=%h dmem_req=%0d reg_we=%0d", obs_pc, obs_ir, obs_dreq, obs_we);
    n_cmp++; if (obs_pc !== RESET_PC + 32'd4 || obs_ir !== I_ADDI || obs_dreq != 0 || obs_we != 1) begin
      n_bad++; $display("FAIL mid_mem_resume: got pc=%h ir=%h dreq=%0d we=%0d want %h/%h/0/1",
                        obs_pc, obs_ir, obs_dreq, obs_we, RESET_PC + 32'd4, I_ADDI);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_store();
    test_illegal_mret();
    test_fetch_timeout();
    test_pc_wrap();
    test_random();
    test_reset_mid_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
